hazard_scoreboard_unit: RTL and testbench
=========================================

// Module: hazard_scoreboard_unit
// PURPOSE
//  Parametrised pipeline hazard controller for the 5-stage core: E/M/W forwarding, load-use stall,
//  branch flush, plus an in-order scoreboard that tracks destination registers of multi-cycle (MCycle) ops.
//  Younger independent instructions keep flowing while MCycle ops are outstanding.
//  Sits beside the datapath; drives all stall/flush/forward selects.
// PARAMETERS
//  AW         5    register address width (2**AW registers, x0 hard-wired zero)
//  MC_DEPTH   2    max outstanding MCycle ops (tag FIFO depth, >=1)
//  MC_TIMEOUT 64   cycles with no pop while ops are pending before MCErr is raised
// PORTS
//  CLK                 in   1    clock, rising edge
//  RESET               in   1    synchronous, active-high
//  rs1D,rs2D,rdD       in   AW   decode-stage source and destination registers
//  RegWriteD,MCOpD     in   1    D writes rd; D holds an MCycle op
//  rs1E,rs2E,rdE       in   AW   execute-stage registers
//  MemtoRegE,MCStartE  in   1    E is a load; E issues an MCycle op this cycle
//  PCSrcE              in   2    PC source selected in E (2'b10/2'b11 = redirect)
//  BranchMispredicted  in   1    misprediction resolved in E
//  rs2M,rdM            in   AW   memory-stage registers
//  RegWriteM,MemWriteM in   1    M control bits
//  rdW                 in   AW   writeback-stage destination register
//  RegWriteW,MemtoRegW in   1    W control bits
//  MCDone              in   1    MCycle unit completes the oldest op (result written this cycle)
//  StallF,StallD,StallE out 1    stage hold enables
//  FlushD,FlushE       out  1    bubble insertion
//  ForwardAE,ForwardBE out  2    00 RF, 01 W, 10 M
//  Forward1D,Forward2D out  2    00 RF, 01 W, 10 MCycle completion
//  ForwardM            out  1    load->store data forward W->M
//  MCBusy              out  1    >=1 MCycle op outstanding
//  MCErr               out  1    sticky timeout flag
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty (count=0); FSM IDLE; timeout counter 0.
//  One clock; reset synchronous, active-high. RESET mid-operation discards all tags and clears MCErr.
//  Forwarding (combinational): M priority over W; never when rd==0; ForwardM=(rs2M==rdW)&MemWriteM&MemtoRegW&rdW!=0.
//  Load-use: lw=MemtoRegE & rdE!=0 & (rs1D==rdE | rs2D==rdE).
//  Scoreboard hit: rs1D/rs2D/(rdD if RegWriteD) equal to any valid tag, rd!=0; the head tag is excluded
//    when MCDone=1, since it is served by Forward*D=10 instead.
//  Structural: MCOpD & (count + MCStartE - MCDone) >= MC_DEPTH.
//  sbStall = scoreboard hit | structural | (FSM==ERR).
//  StallF=StallD=lw|sbStall; StallE=0; FlushE=lw|sbStall|redirect; FlushD=redirect.
//  redirect = PCSrcE[1] | BranchMispredicted; redirect overrides stall for FlushD.
//  Push tag rdE on MCStartE; pop head on MCDone; simultaneous push+pop leaves count unchanged.
//  Push when full and pop when empty are protocol errors: ignored and flagged by an assertion.
//  FSM: IDLE -(push)-> BUSY; BUSY -(count reaches 0)-> IDLE; BUSY -(timer==MC_TIMEOUT-1)-> ERR;
//    ERR exits only on RESET.
//  Timer increments each cycle in BUSY with no pop; resets to 0 on pop. MCBusy = (FSM!=IDLE).
// CONFIGURATION
//  HAZ_PERF_EN defined: adds outputs StallCnt[31:0] and FlushCnt[31:0].
//    Each counts cycles with StallD=1 / FlushE=1, wraps at 2**32, clears on RESET.
//  HAZ_PERF_EN undefined: the ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  hazard_pkg: localparams FWD_RF/FWD_W/FWD_M/FWD_MC, FSM state encodings IDLE/BUSY/ERR.
//  Sub-module mc_tag_fifo: MC_DEPTH x AW circular buffer with head, valid vector and count.
//    Exposes a parallel compare of 3 read addresses against valid entries (hit vector).
// TESTING
//  add x5 then sub using x5 in the next instruction -> ForwardAE=10; one cycle later -> ForwardAE=01.
//  lw x6; add x7,x6,x1 -> StallF=StallD=FlushE=1 for exactly 1 cycle; rdE=0 load -> no stall.
//  MCStartE rd=x8, then independent add, then use of x8 -> add flows; user stalls in D until MCDone.
//    On the MCDone cycle Forward1D=10; stall drops the same cycle.
//  MC_DEPTH=2: two MCycle ops outstanding, third in D -> structural stall.
//    Push+pop in the same cycle keeps count=2; third issues next cycle.
//  No MCDone for MC_TIMEOUT cycles -> MCErr=1 and permanent stall; RESET -> all outputs 0, FSM IDLE.
//  Redirect (BranchMispredicted=1) concurrent with load-use -> FlushD=FlushE=1.
//    With HAZ_PERF_EN, FlushCnt increments by 1.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard controller.
// Forwarding select codes and MCycle tracker FSM states.
package hazard_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;
    localparam logic [1:0] FWD_MC = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } mc_state_e;

endpackage

// File: rtl/mc_tag_fifo.sv
// In-order tag FIFO for outstanding MCycle destinations.
// Circular buffer with valid vector and a 3-port parallel tag compare.
module mc_tag_fifo
    import hazard_pkg::*;
#(
    parameter int AW    = 5,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [AW-1:0]    tag_i,
    input  logic             pop_i,
    input  logic [AW-1:0]    addr1_i,
    input  logic [AW-1:0]    addr2_i,
    input  logic [AW-1:0]    addr3_i,
    output logic [DEPTH-1:0] hit1_o,
    output logic [DEPTH-1:0] hit2_o,
    output logic [DEPTH-1:0] hit3_o,
    output logic [DEPTH-1:0] head_oh_o,
    output logic [AW-1:0]    head_tag_o,
    output logic [CW-1:0]    count_o,
    output logic             empty_o,
    output logic             push_ok_o,
    output logic             pop_ok_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0][AW-1:0] tag_q, tag_d;
    logic [DEPTH-1:0]         valid_q, valid_d;
    logic [PW-1:0]            head_q, head_d;
    logic [CW-1:0]            count_q, count_d;
    logic [PW-1:0]            tail;
    logic                     full;

    function automatic logic [PW-1:0] wrap(input int p);
        return (p >= DEPTH) ? PW'(p - DEPTH) : PW'(p);
    endfunction

    assign empty_o   = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign pop_ok_o  = pop_i & ~empty_o;
    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign push_ok_o = push_i & (~full | pop_ok_o);
    assign tail      = wrap(int'(head_q) + int'(count_q));

    always_comb begin
        tag_d   = tag_q;
        valid_d = valid_q;
        head_d  = head_q;
        if (pop_ok_o) begin
            valid_d[head_q] = 1'b0;
            head_d          = wrap(int'(head_q) + 1);
        end
        if (push_ok_o) begin
            tag_d[tail]   = tag_i;
            valid_d[tail] = 1'b1;
        end
        count_d = count_q + CW'(push_ok_o) - CW'(pop_ok_o);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q   <= '0;
            valid_q <= '0;
            head_q  <= '0;
            count_q <= '0;
        end else begin
            tag_q   <= tag_d;
            valid_q <= valid_d;
            head_q  <= head_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        head_oh_o         = '0;
        head_oh_o[head_q] = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            hit1_o[i] = valid_q[i] & (tag_q[i] == addr1_i);
            hit2_o[i] = valid_q[i] & (tag_q[i] == addr2_i);
            hit3_o[i] = valid_q[i] & (tag_q[i] == addr3_i);
        end
    end

    assign head_tag_o = tag_q[head_q];
    assign count_o    = count_q;

    a_no_push_full: assert property (
        @(posedge clk) disable iff (rst) !(push_i && full && !pop_i));
    a_no_pop_empty: assert property (
        @(posedge clk) disable iff (rst) !(pop_i && empty_o));

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// 5-stage hazard controller: forwarding, load-use, flush, MCycle scoreboard.
// Define HAZ_PERF_EN to add StallCnt/FlushCnt performance counters.
module hazard_scoreboard_unit
    import hazard_pkg::*;
#(
    parameter int AW         = 5,
    parameter int MC_DEPTH   = 2,
    parameter int MC_TIMEOUT = 64
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [AW-1:0] rs1D,
    input  logic [AW-1:0] rs2D,
    input  logic [AW-1:0] rdD,
    input  logic          RegWriteD,
    input  logic          MCOpD,
    input  logic [AW-1:0] rs1E,
    input  logic [AW-1:0] rs2E,
    input  logic [AW-1:0] rdE,
    input  logic          MemtoRegE,
    input  logic          MCStartE,
    input  logic [1:0]    PCSrcE,
    input  logic          BranchMispredicted,
    input  logic [AW-1:0] rs2M,
    input  logic [AW-1:0] rdM,
    input  logic          RegWriteM,
    input  logic          MemWriteM,
    input  logic [AW-1:0] rdW,
    input  logic          RegWriteW,
    input  logic          MemtoRegW,
    input  logic          MCDone,
    output logic          StallF,
    output logic          StallD,
    output logic          StallE,
    output logic          FlushD,
    output logic          FlushE,
    output logic [1:0]    ForwardAE,
    output logic [1:0]    ForwardBE,
    output logic [1:0]    Forward1D,
    output logic [1:0]    Forward2D,
    output logic          ForwardM,
    output logic          MCBusy,
    output logic          MCErr
`ifdef HAZ_PERF_EN
    ,
    output logic [31:0]   StallCnt,
    output logic [31:0]   FlushCnt
`endif
);

    localparam int CW = $clog2(MC_DEPTH + 1);
    localparam int TW = $clog2(MC_TIMEOUT) + 1;

    logic [MC_DEPTH-1:0] hit1, hit2, hit3, head_oh, live;
    logic [AW-1:0]       head_tag;
    logic [CW-1:0]       mc_count;
    logic                mc_empty, mc_push, mc_pop, mc_drain;
    logic                lw_stall, sb_hit, struct_stall, sb_stall;
    logic                stall, redirect, flush_e, in_err;
    logic                mc_fwd;
    int                  occ;
    mc_state_e           state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic                unused_pcsrc;

    assign unused_pcsrc = PCSrcE[0];

    mc_tag_fifo #(
        .AW    (AW),
        .DEPTH (MC_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk        (CLK),
        .rst        (RESET),
        .push_i     (MCStartE),
        .tag_i      (rdE),
        .pop_i      (MCDone),
        .addr1_i    (rs1D),
        .addr2_i    (rs2D),
        .addr3_i    (rdD),
        .hit1_o     (hit1),
        .hit2_o     (hit2),
        .hit3_o     (hit3),
        .head_oh_o  (head_oh),
        .head_tag_o (head_tag),
        .count_o    (mc_count),
        .empty_o    (mc_empty),
        .push_ok_o  (mc_push),
        .pop_ok_o   (mc_pop)
    );

    always_comb begin
        ForwardAE = FWD_RF;
        if (RegWriteM && rdM != '0 && rs1E == rdM)
            ForwardAE = FWD_M;
        else if (RegWriteW && rdW != '0 && rs1E == rdW)
            ForwardAE = FWD_W;

        ForwardBE = FWD_RF;
        if (RegWriteM && rdM != '0 && rs2E == rdM)
            ForwardBE = FWD_M;
        else if (RegWriteW && rdW != '0 && rs2E == rdW)
            ForwardBE = FWD_W;
    end

    // The completing head result is bypassed into D, so it no longer blocks.
    assign mc_fwd = MCDone & ~mc_empty;
    assign live   = MCDone ? ~head_oh : '1;

    always_comb begin
        Forward1D = FWD_RF;
        if (mc_fwd && rs1D != '0 && rs1D == head_tag)
            Forward1D = FWD_MC;
        else if (RegWriteW && rdW != '0 && rs1D == rdW)
            Forward1D = FWD_W;

        Forward2D = FWD_RF;
        if (mc_fwd && rs2D != '0 && rs2D == head_tag)
            Forward2D = FWD_MC;
        else if (RegWriteW && rdW != '0 && rs2D == rdW)
            Forward2D = FWD_W;
    end

    assign ForwardM = (rs2M == rdW) & MemWriteM & MemtoRegW & (rdW != '0);

    assign lw_stall = MemtoRegE & (rdE != '0) & ((rs1D == rdE) | (rs2D == rdE));

    assign sb_hit = ((rs1D != '0) & |(hit1 & live))
                  | ((rs2D != '0) & |(hit2 & live))
                  | (RegWriteD & (rdD != '0) & |(hit3 & live));

    assign occ          = int'(mc_count) + int'(MCStartE) - int'(MCDone);
    assign struct_stall = MCOpD & (occ >= MC_DEPTH);
    assign sb_stall     = sb_hit | struct_stall | in_err;

    assign stall    = lw_stall | sb_stall;
    assign redirect = PCSrcE[1] | BranchMispredicted;
    assign flush_e  = stall | redirect;

    assign StallF = stall;
    assign StallD = stall;
    assign StallE = 1'b0;
    assign FlushD = redirect;
    assign FlushE = flush_e;

    assign mc_drain = (int'(mc_count) + int'(mc_push) - int'(mc_pop)) == 0;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                if (mc_push)
                    state_d = BUSY;
            end
            BUSY: begin
                if (mc_drain) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (mc_pop) begin
                    timer_d = '0;
                end else if (timer_q == TW'(MC_TIMEOUT - 1)) begin
                    state_d = ERR;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_comb begin
        in_err = (state_q == ERR);
        MCBusy = (state_q != IDLE);
        MCErr  = (state_q == ERR);
    end

`ifdef HAZ_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'b0, stall};
        flush_cnt_d = flush_cnt_q + {31'b0, flush_e};
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_hazard_scoreboard_unit;

    localparam int AW    = 5;
    localparam int DEPTH = 2;
    localparam int TMO   = 64;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [AW-1:0] rs1D, rs2D, rdD, rs1E, rs2E, rdE, rs2M, rdM, rdW;
    logic          RegWriteD, MCOpD, MemtoRegE, MCStartE;
    logic [1:0]    PCSrcE;
    logic          BranchMispredicted, RegWriteM, MemWriteM;
    logic          RegWriteW, MemtoRegW, MCDone;
    logic          StallF, StallD, StallE, FlushD, FlushE, ForwardM;
    logic          MCBusy, MCErr;
    logic [1:0]    ForwardAE, ForwardBE, Forward1D, Forward2D;
`ifdef HAZ_PERF_EN
    logic [31:0]   StallCnt, FlushCnt;
`endif

    always #5 CLK = ~CLK;

    hazard_scoreboard_unit #(
        .AW(AW), .MC_DEPTH(DEPTH), .MC_TIMEOUT(TMO)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD),
        .RegWriteD(RegWriteD), .MCOpD(MCOpD),
        .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
        .MemtoRegE(MemtoRegE), .MCStartE(MCStartE),
        .PCSrcE(PCSrcE), .BranchMispredicted(BranchMispredicted),
        .rs2M(rs2M), .rdM(rdM),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .rdW(rdW), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
        .MCDone(MCDone),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .Forward1D(Forward1D), .Forward2D(Forward2D),
        .ForwardM(ForwardM), .MCBusy(MCBusy), .MCErr(MCErr)
`ifdef HAZ_PERF_EN
        , .StallCnt(StallCnt), .FlushCnt(FlushCnt)
`endif
    );

    int passed = 0;
    int total  = 0;

    // Reference model: outstanding MCycle destinations, oldest first.
    int          q[$];
    int          m_timer;
    int          m_state;   // 0 idle, 1 busy, 2 error
    int unsigned m_stall_cnt, m_flush_cnt;

    logic [15:0] act;
    assign act = {StallF, StallD, StallE, FlushD, FlushE,
                  ForwardAE, ForwardBE, Forward1D, Forward2D,
                  ForwardM, MCBusy, MCErr};

    function automatic logic [1:0] fwd_e(input logic [AW-1:0] rs);
        if (RegWriteM && rdM != 0 && rs == rdM) return 2'b10;
        if (RegWriteW && rdW != 0 && rs == rdW) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [1:0] fwd_d(input logic [AW-1:0] rs);
        if (MCDone && q.size() > 0 && rs != 0 && q[0] == int'(rs)) return 2'b10;
        if (RegWriteW && rdW != 0 && rs == rdW) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit tag_busy(input logic [AW-1:0] r);
        if (r == 0) return 1'b0;
        for (int i = 0; i < q.size(); i++)
            if (!(i == 0 && MCDone) && q[i] == int'(r)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [15:0] model_outs();
        bit lw, sb, rd, st, fm;
        int occ;
        lw  = MemtoRegE && rdE != 0 && (rs1D == rdE || rs2D == rdE);
        occ = q.size() + int'(MCStartE) - int'(MCDone);
        sb  = tag_busy(rs1D) || tag_busy(rs2D) || (RegWriteD && tag_busy(rdD))
            || (MCOpD && occ >= DEPTH) || m_state == 2;
        rd  = PCSrcE[1] || BranchMispredicted;
        st  = lw || sb;
        fm  = (rs2M == rdW) && MemWriteM && MemtoRegW && rdW != 0;
        return {st, st, 1'b0, rd, st || rd, fwd_e(rs1E), fwd_e(rs2E),
                fwd_d(rs1D), fwd_d(rs2D), fm, m_state != 0, m_state == 2};
    endfunction

    task automatic model_update();
        logic [15:0] e;
        bit pop, push;
        if (RESET) begin
            q.delete();
            m_timer = 0; m_state = 0;
            m_stall_cnt = 0; m_flush_cnt = 0;
            return;
        end
        e = model_outs();
        if (e[14]) m_stall_cnt++;
        if (e[11]) m_flush_cnt++;
        pop  = MCDone && q.size() > 0;
        push = MCStartE && (q.size() < DEPTH || pop);
        if (pop) void'(q.pop_front());
        if (push) q.push_back(int'(rdE));
        if (m_state == 0) begin
            if (push) begin m_state = 1; m_timer = 0; end
        end else if (m_state == 1) begin
            if (q.size() == 0) begin m_state = 0; m_timer = 0; end
            else if (pop) m_timer = 0;
            else if (m_timer == TMO - 1) m_state = 2;
            else m_timer++;
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        {rs1D, rs2D, rdD, rs1E, rs2E, rdE, rs2M, rdM, rdW} = '0;
        {RegWriteD, MCOpD, MemtoRegE, MCStartE} = '0;
        PCSrcE = 2'b00;
        {BranchMispredicted, RegWriteM, MemWriteM} = '0;
        {RegWriteW, MemtoRegW, MCDone} = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        RESET = 1'b1;
        tick(); tick();
        #2;
        total++;
        if (act !== 16'h0) $display("FAIL reset_outs: got %h want %h", act, 16'h0);
        else passed++;
        RESET = 1'b0;
        #1;
`ifdef HAZ_PERF_EN
        total++;
        if ({StallCnt, FlushCnt} !== 64'h0)
            $display("FAIL reset_cnt: got %h/%h want 0/0", StallCnt, FlushCnt);
        else passed++;
`endif
    endtask

    task automatic test_forward();
        clear_inputs();
        RegWriteM = 1; rdM = 5; rs1E = 5; rs2E = 5;
        #2;
        total++;
        if (ForwardAE !== 2'b10) $display("FAIL fwdAE_M: got %b want 10", ForwardAE);
        else passed++;
        tick();
        RegWriteM = 0; rdM = 7; RegWriteW = 1; rdW = 5;
        #2;
        total++;
        if (ForwardAE !== 2'b01) $display("FAIL fwdAE_W: got %b want 01", ForwardAE);
        else passed++;
        RegWriteM = 1; rdM = 5;
        #2;
        total++;
        if (ForwardBE !== 2'b10) $display("FAIL fwdBE_prio: got %b want 10", ForwardBE);
        else passed++;
        rdM = 0; rdW = 0; rs1E = 0;
        #2;
        total++;
        if (ForwardAE !== 2'b00) $display("FAIL fwd_x0: got %b want 00", ForwardAE);
        else passed++;
        clear_inputs();
        rs2M = 3; rdW = 3; MemWriteM = 1; MemtoRegW = 1;
        #2;
        total++;
        if (ForwardM !== 1'b1) $display("FAIL fwdM_on: got %b want 1", ForwardM);
        else passed++;
        rs2M = 0; rdW = 0;
        #2;
        total++;
        if (ForwardM !== 1'b0) $display("FAIL fwdM_x0: got %b want 0", ForwardM);
        else passed++;
        tick();
    endtask

    task automatic test_load_use();
        clear_inputs();
        MemtoRegE = 1; rdE = 6; rs1D = 6; rs2D = 1;
        #2;
        total++;
        if ({StallF, StallD, FlushE} !== 3'b111)
            $display("FAIL lw_stall: got %b want 111", {StallF, StallD, FlushE});
        else passed++;
        tick();
        MemtoRegE = 0; rdE = 0;
        #2;
        total++;
        if ({StallF, StallD, FlushE} !== 3'b000)
            $display("FAIL lw_release: got %b want 000", {StallF, StallD, FlushE});
        else passed++;
        MemtoRegE = 1; rdE = 0; rs1D = 0;
        #2;
        total++;
        if (StallD !== 1'b0) $display("FAIL lw_x0: got %b want 0", StallD);
        else passed++;
        tick();
    endtask

    task automatic test_mcycle();
        clear_inputs();
        MCStartE = 1; rdE = 8;
        rs1D = 1; rs2D = 2; rdD = 9; RegWriteD = 1;
        #2;
        total++;
        if (StallD !== 1'b0) $display("FAIL mc_indep: got %b want 0", StallD);
        else passed++;
        tick();
        clear_inputs();
        rs1D = 8; rs2D = 1; rdD = 10; RegWriteD = 1;
        for (int i = 0; i < 3; i++) begin
            #2;
            total++;
            if ({StallD, MCBusy} !== 2'b11)
                $display("FAIL mc_user_wait: got %b want 11", {StallD, MCBusy});
            else passed++;
            tick();
        end
        MCDone = 1;
        #2;
        total++;
        if ({StallD, Forward1D} !== 3'b010)
            $display("FAIL mc_done_fwd: got %b want 010", {StallD, Forward1D});
        else passed++;
        tick();
        clear_inputs();
        #2;
        total++;
        if (MCBusy !== 1'b0) $display("FAIL mc_idle: got %b want 0", MCBusy);
        else passed++;
    endtask

    task automatic test_structural();
        clear_inputs();
        MCStartE = 1; rdE = 8; tick();
        rdE = 9; tick();
        clear_inputs();
        MCOpD = 1; rs1D = 1; rs2D = 2; rdD = 10; RegWriteD = 1;
        #2;
        total++;
        if (StallD !== 1'b1) $display("FAIL struct_full: got %b want 1", StallD);
        else passed++;
        MCStartE = 1; rdE = 12; MCDone = 1;
        #2;
        total++;
        if (StallD !== 1'b1) $display("FAIL struct_swap: got %b want 1", StallD);
        else passed++;
        tick();
        MCStartE = 0;
        #2;
        total++;
        if ({StallD, MCBusy} !== 2'b01)
            $display("FAIL struct_free: got %b want 01", {StallD, MCBusy});
        else passed++;
        tick();
        MCOpD = 0; MCStartE = 1; rdE = 10; tick();
        MCStartE = 0; tick();
        clear_inputs();
        #2;
        total++;
        if (MCBusy !== 1'b0) $display("FAIL struct_drain: got %b want 0", MCBusy);
        else passed++;
    endtask

    task automatic test_timeout();
        clear_inputs();
        MCStartE = 1; rdE = 8; tick();
        clear_inputs();
        repeat (TMO - 1) tick();
        #2;
        total++;
        if ({MCBusy, MCErr} !== 2'b10)
            $display("FAIL tmo_early: got %b want 10", {MCBusy, MCErr});
        else passed++;
        tick();
        #2;
        total++;
        if ({MCErr, StallD, FlushE} !== 3'b111)
            $display("FAIL tmo_err: got %b want 111", {MCErr, StallD, FlushE});
        else passed++;
        MCDone = 1; tick(); MCDone = 0;
        #2;
        total++;
        if (MCErr !== 1'b1) $display("FAIL tmo_sticky: got %b want 1", MCErr);
        else passed++;
        RESET = 1; tick(); RESET = 0;
        #2;
        total++;
        if (act !== 16'h0) $display("FAIL tmo_reset: got %h want %h", act, 16'h0);
        else passed++;
    endtask

    task automatic test_redirect();
`ifdef HAZ_PERF_EN
        logic [31:0] f0;
`endif
        clear_inputs();
        MemtoRegE = 1; rdE = 6; rs1D = 6; BranchMispredicted = 1;
        #2;
        total++;
        if ({FlushD, FlushE, StallD} !== 3'b111)
            $display("FAIL redir_lw: got %b want 111", {FlushD, FlushE, StallD});
        else passed++;
`ifdef HAZ_PERF_EN
        f0 = FlushCnt;
`endif
        tick();
`ifdef HAZ_PERF_EN
        total++;
        if (FlushCnt !== f0 + 32'd1)
            $display("FAIL redir_cnt: got %0d want %0d", FlushCnt, f0 + 32'd1);
        else passed++;
`endif
        clear_inputs();
        PCSrcE = 2'b10;
        #2;
        total++;
        if ({FlushD, FlushE, StallD} !== 3'b110)
            $display("FAIL redir_pc: got %b want 110", {FlushD, FlushE, StallD});
        else passed++;
        PCSrcE = 2'b01;
        #2;
        total++;
        if ({FlushD, FlushE} !== 2'b00)
            $display("FAIL redir_none: got %b want 00", {FlushD, FlushE});
        else passed++;
        tick();
    endtask

    function automatic logic [AW-1:0] rnd_reg();
        if ($urandom_range(0, 7) == 0) return AW'($urandom);
        return AW'($urandom_range(0, 3));
    endfunction

    task automatic test_random();
        logic [15:0] exp;
        for (int n = 0; n < 600; n++) begin
            RESET = ($urandom_range(0, 99) == 0);
            rs1D = rnd_reg(); rs2D = rnd_reg(); rdD = rnd_reg();
            rs1E = rnd_reg(); rs2E = rnd_reg(); rdE = rnd_reg();
            rs2M = rnd_reg(); rdM = rnd_reg(); rdW = rnd_reg();
            RegWriteD = 1'($urandom); MCOpD = ($urandom_range(0, 3) == 0);
            MemtoRegE = ($urandom_range(0, 3) == 0);
            PCSrcE = 2'($urandom);
            BranchMispredicted = ($urandom_range(0, 7) == 0);
            RegWriteM = 1'($urandom); MemWriteM = 1'($urandom);
            RegWriteW = 1'($urandom); MemtoRegW = 1'($urandom);
            MCDone = (q.size() > 0) && ($urandom_range(0, 2) == 0);
            MCStartE = (q.size() < DEPTH || MCDone) && ($urandom_range(0, 2) == 0);
            #2;
            exp = model_outs();
            total++;
            if (act !== exp) $display("FAIL rand_outs[%0d]: got %h want %h", n, act, exp);
            else passed++;
`ifdef HAZ_PERF_EN
            total++;
            if (StallCnt !== m_stall_cnt || FlushCnt !== m_flush_cnt)
                $display("FAIL rand_cnt[%0d]: got %0d/%0d want %0d/%0d", n,
                         StallCnt, FlushCnt, m_stall_cnt, m_flush_cnt);
            else passed++;
`endif
            tick();
        end
        RESET = 0;
    endtask

    initial begin
        RESET = 1'b1;
        clear_inputs();
        #1;
        test_reset();
        test_forward();
        test_load_use();
        test_mcycle();
        test_structural();
        test_timeout();
        test_redirect();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
